lieat_ifu_ifetch_rsp: RTL and testbench
=======================================

Name: lieat_ifu_ifetch_rsp

Overview:
- Fetch-response stage of the IFU; sits directly downstream of the ifetch request stage.
- Takes one fetch PC per handshake and issues a single-beat read on the instruction bus (AR/R channels, AXI-lite style).
- Returns instruction + PC to the IDU over valid/ready.
- Pulses rsp_o_ifsh back to the request stage on every delivered instruction. Drops in-flight responses on flush.

Parameters:
- ADDR_W, `XLEN, instruction bus address width.
- DATA_W, 32, instruction bus data width; fixed at 32 (no compressed instructions).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- req_i_valid  in  1  fetch request valid (from request stage)
- req_i_pc  in  `XLEN  fetch PC
- req_i_ready  out  1  request accepted this cycle
- req_i_flush  in  1  pipeline flush; the same-cycle request carries the flush PC
- bus_arvalid  out  1  read address valid
- bus_araddr  out  `XLEN  read address (= latched PC)
- bus_arready  in  1  address accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  instruction word
- bus_rresp  in  2  0 = OKAY; non-zero = error
- bus_rready  out  1  read data accept
- rsp_o_valid  out  1  instruction valid to IDU
- rsp_o_ready  in  1  IDU accepts
- rsp_o_pc  out  `XLEN  PC of delivered instruction
- rsp_o_instr  out  32  instruction word
- rsp_o_err  out  1  bus or alignment error on this fetch
- rsp_o_ifsh  out  1  one-cycle pulse = rsp_o_valid & rsp_o_ready

Behaviour:
- FSM states: IDLE, AR, R, OUT. Reset: IDLE, drop flag = 0, pend_valid = 0, every output 0 except req_i_ready = 1.
- IDLE: req_i_ready = 1. On req_i_valid, latch PC, go to AR (bus_arvalid asserted next cycle). Latency from request handshake to arvalid = 1 cycle.
- AR: bus_arvalid = 1 with bus_araddr stable until bus_arready; then go to R. arvalid is never withdrawn before arready, even on flush.
- R: bus_rready = 1. On bus_rvalid:
  - drop = 0: capture rdata and err = (rresp != 0), go to OUT.
  - drop = 1: discard, clear drop, go to AR if pend_valid, else IDLE.
- OUT: rsp_o_valid = 1; pc, instr and err held stable until rsp_o_ready.
  - Handshake alone: rsp_o_ifsh = 1, go to IDLE.
  - Handshake with req_i_valid in the same cycle: req_i_ready = 1, latch the new PC, go straight to AR (zero bubble).
- Flush (req_i_flush = 1): req_i_ready is forced to 1 in every state.
  - IDLE: normal accept.
  - OUT: rsp_o_valid dropped the same cycle (combinationally gated), no ifsh; new PC latched, go to AR.
  - AR or R: set drop = 1, store PC in the pending register (pend_valid = 1), keep the bus transaction running. After the dropped beat, issue the pending PC.
  - A second flush while pending overwrites the pending PC.
- Only one bus transaction outstanding at any time.
- rsp_o_ifsh never fires for a dropped or flushed instruction.
- Reset mid-transaction returns to IDLE. The bus slave is reset on the same signal.

Optional Feature:
- Macro: LIEAT_IFU_MISALIGN_CHK_EN.
- Defined: a request with pc[1:0] != 0 skips the bus entirely and goes IDLE -> OUT with rsp_o_err = 1 and rsp_o_instr = 0 (1-cycle latency).
- Undefined: the PC is sent to the bus unchanged; any error comes only from rresp.

Decomposition:
- Shared package/defines: `XLEN, FSM state encodings (IFR_IDLE/AR/R/OUT, 2 bits), RESP_OKAY = 2'b00.
- Sub-module: lieat_ifu_rsp_pend, a 1-entry pending-flush register (valid + PC, set/overwrite/clear) built on lieat_general_dfflr.

Test Plan:
- Basic fetch: request pc = 0x8000_0000, arready after 1 cycle, rvalid with rdata = 0x0000_0013 after 2 cycles, rsp_o_ready = 1 -> rsp_o_valid with pc 0x8000_0000, instr 0x13, err 0; one ifsh pulse.
- Back-pressure: rsp_o_ready low for 5 cycles -> outputs stable, req_i_ready = 0, no second arvalid; ready goes high -> ifsh the same cycle.
- Flush in R: flush with pc 0x8000_0100 while waiting for rvalid -> old rdata discarded with no rsp_o_valid; next araddr = 0x8000_0100.
- Double flush in AR: flush 0x100, then 0x200 before arready -> only 0x200 is fetched after the dropped beat.
- Bus error: rresp = 2'b10 -> rsp_o_err = 1 with the correct PC.
- With LIEAT_IFU_MISALIGN_CHK_EN: pc 0x8000_0002 -> no arvalid, rsp_o_err = 1 on the next cycle.

Source files
------------

// File: rtl/lieat_ifu_ifetch_rsp_pkg.sv
// ============================================================================
//  Module      : lieat_ifu_ifetch_rsp_pkg
//  Description : Shared width define, FSM state encodings and bus response
//                constants for the IFU fetch-response stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package lieat_ifu_ifetch_rsp_pkg;

    typedef enum logic [1:0] {
        IFR_IDLE = 2'd0,
        IFR_AR   = 2'd1,
        IFR_R    = 2'd2,
        IFR_OUT  = 2'd3
    } ifr_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Instructions are 32-bit only, so any nonzero low PC bits are illegal.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lieat_general_dfflr.sv
// ============================================================================
//  Module      : lieat_general_dfflr
//  Description : Generic load-enabled flop with synchronous active-high reset
//                to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lieat_general_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);

    logic [DW-1:0] r_q;

    // Hold value unless load is requested; reset clears to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_lden) begin
            r_q <= i_dnxt;
        end
    end

    assign o_qout = r_q;

endmodule

`default_nettype wire

// File: rtl/lieat_ifu_rsp_pend.sv
// ============================================================================
//  Module      : lieat_ifu_rsp_pend
//  Description : One-entry pending-flush register. Holds the flush PC that
//                must be fetched once the in-flight (dropped) beat retires.
//                Set overwrites any earlier entry; set wins over clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lieat_ifu_rsp_pend #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_pc,
    input  logic              i_clr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc
);

    logic w_valid_ld;

    assign w_valid_ld = i_set | i_clr;

    lieat_general_dfflr #(.DW(1)) u_valid (
        .clk    (clk),
        .rst    (rst),
        .i_lden (w_valid_ld),
        .i_dnxt (i_set),
        .o_qout (o_valid)
    );

    lieat_general_dfflr #(.DW(ADDR_W)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .i_lden (i_set),
        .i_dnxt (i_set_pc),
        .o_qout (o_pc)
    );

endmodule

`default_nettype wire

// File: rtl/lieat_ifu_ifetch_rsp.sv
// ============================================================================
//  Module      : lieat_ifu_ifetch_rsp
//  Description : IFU fetch-response stage. Accepts one fetch PC per
//                handshake, issues a single-beat AR/R read, and returns the
//                instruction word and PC to the IDU. Flushes during an open
//                bus transaction mark the beat for dropping and queue the
//                flush PC in a one-entry pending register.
//                Optional: LIEAT_IFU_MISALIGN_CHK_EN - misaligned PCs bypass
//                the bus and return an error response directly.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lieat_ifu_ifetch_rsp
    import lieat_ifu_ifetch_rsp_pkg::*;
#(
    parameter int ADDR_W = `XLEN,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_i_valid,
    input  logic [ADDR_W-1:0] req_i_pc,
    output logic              req_i_ready,
    input  logic              req_i_flush,
    output logic              bus_arvalid,
    output logic [ADDR_W-1:0] bus_araddr,
    input  logic              bus_arready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic [1:0]        bus_rresp,
    output logic              bus_rready,
    output logic              rsp_o_valid,
    input  logic              rsp_o_ready,
    output logic [ADDR_W-1:0] rsp_o_pc,
    output logic [DATA_W-1:0] rsp_o_instr,
    output logic              rsp_o_err,
    output logic              rsp_o_ifsh
);

    ifr_state_e        r_state;
    ifr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_err;
    logic              r_drop;

    logic              w_drop_nxt;
    logic              w_data_ld;
    logic [DATA_W-1:0] w_instr_nxt;
    logic              w_err_nxt;
    logic              w_launch;
    logic [ADDR_W-1:0] w_launch_pc;
    logic              w_launch_mis;
    logic              w_pc_ld;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_pend_valid;
    logic [ADDR_W-1:0] w_pend_pc;

    lieat_ifu_rsp_pend #(.ADDR_W(ADDR_W)) u_pend (
        .clk      (clock),
        .rst      (reset),
        .i_set    (w_pend_set),
        .i_set_pc (req_i_pc),
        .i_clr    (w_pend_clr),
        .o_valid  (w_pend_valid),
        .o_pc     (w_pend_pc)
    );

    // Flush forces acceptance anywhere; otherwise accept when idle or when
    // the held response is being consumed (zero-bubble refetch).
    assign req_i_ready = req_i_flush
                       | (r_state == IFR_IDLE)
                       | ((r_state == IFR_OUT) & rsp_o_ready);

    assign bus_arvalid = (r_state == IFR_AR);
    assign bus_araddr  = r_pc;
    assign bus_rready  = (r_state == IFR_R);

    // A flush kills the held response in the same cycle it arrives.
    assign rsp_o_valid = (r_state == IFR_OUT) & ~req_i_flush;
    assign rsp_o_ifsh  = rsp_o_valid & rsp_o_ready;
    assign rsp_o_pc    = r_pc;
    assign rsp_o_instr = r_instr;
    assign rsp_o_err   = r_err;

    // Next-state, drop/pending control and new-fetch launch decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop;
        w_data_ld    = 1'b0;
        w_instr_nxt  = bus_rdata;
        w_err_nxt    = (bus_rresp != RESP_OKAY);
        w_launch     = 1'b0;
        w_launch_pc  = req_i_pc;
        w_launch_mis = 1'b0;
        w_pc_ld      = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;

        case (r_state)
            IFR_IDLE: begin
                if (req_i_valid | req_i_flush) begin
                    w_launch = 1'b1;
                end
            end
            IFR_AR: begin
                // Address phase must complete even when flushed.
                if (req_i_flush) begin
                    w_drop_nxt = 1'b1;
                    w_pend_set = 1'b1;
                end
                if (bus_arready) begin
                    w_state_nxt = IFR_R;
                end
            end
            IFR_R: begin
                if (bus_rvalid) begin
                    if (req_i_flush) begin
                        // Beat dies with the flush; fetch the flush PC now.
                        w_drop_nxt = 1'b0;
                        w_pend_clr = 1'b1;
                        w_launch   = 1'b1;
                    end else if (r_drop) begin
                        w_drop_nxt = 1'b0;
                        if (w_pend_valid) begin
                            w_pend_clr  = 1'b1;
                            w_launch    = 1'b1;
                            w_launch_pc = w_pend_pc;
                        end else begin
                            w_state_nxt = IFR_IDLE;
                        end
                    end else begin
                        w_data_ld   = 1'b1;
                        w_state_nxt = IFR_OUT;
                    end
                end else if (req_i_flush) begin
                    w_drop_nxt = 1'b1;
                    w_pend_set = 1'b1;
                end
            end
            IFR_OUT: begin
                if (req_i_flush) begin
                    w_launch = 1'b1;
                end else if (rsp_o_ready) begin
                    if (req_i_valid) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt = IFR_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IFR_IDLE;
            end
        endcase

`ifdef LIEAT_IFU_MISALIGN_CHK_EN
        w_launch_mis = pc_misaligned(w_launch_pc[1:0]);
`else
        w_launch_mis = 1'b0;
`endif

        // Common launch: latch the PC, then either go to the bus or return
        // an error response directly for a misaligned PC.
        if (w_launch) begin
            w_pc_ld = 1'b1;
            if (w_launch_mis) begin
                w_data_ld   = 1'b1;
                w_instr_nxt = '0;
                w_err_nxt   = 1'b1;
                w_state_nxt = IFR_OUT;
            end else begin
                w_state_nxt = IFR_AR;
            end
        end
    end

    // State, PC, response data and drop flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IFR_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_err   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (w_pc_ld) begin
                r_pc <= w_launch_pc;
            end
            if (w_data_ld) begin
                r_instr <= w_instr_nxt;
                r_err   <= w_err_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lieat_ifu_ifetch_rsp.sv
// ============================================================================
//  Module      : tb_lieat_ifu_ifetch_rsp
//  Description : Directed self-checking bench for lieat_ifu_ifetch_rsp.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lieat_ifu_ifetch_rsp;

    logic        clk;
    logic        rst;
    logic        req_i_valid;
    logic [31:0] req_i_pc;
    logic        req_i_ready;
    logic        req_i_flush;
    logic        bus_arvalid;
    logic [31:0] bus_araddr;
    logic        bus_arready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_rresp;
    logic        bus_rready;
    logic        rsp_o_valid;
    logic        rsp_o_ready;
    logic [31:0] rsp_o_pc;
    logic [31:0] rsp_o_instr;
    logic        rsp_o_err;
    logic        rsp_o_ifsh;

    int n_checks = 0;
    int n_errors = 0;

    lieat_ifu_ifetch_rsp #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clock       (clk),
        .reset       (rst),
        .req_i_valid (req_i_valid),
        .req_i_pc    (req_i_pc),
        .req_i_ready (req_i_ready),
        .req_i_flush (req_i_flush),
        .bus_arvalid (bus_arvalid),
        .bus_araddr  (bus_araddr),
        .bus_arready (bus_arready),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .bus_rresp   (bus_rresp),
        .bus_rready  (bus_rready),
        .rsp_o_valid (rsp_o_valid),
        .rsp_o_ready (rsp_o_ready),
        .rsp_o_pc    (rsp_o_pc),
        .rsp_o_instr (rsp_o_instr),
        .rsp_o_err   (rsp_o_err),
        .rsp_o_ifsh  (rsp_o_ifsh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge and
    // outputs sampled after a further 1ns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Request pc, immediate arready, immediate rvalid; returns in OUT.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input logic [1:0] resp);
        req_i_valid = 1'b1;
        req_i_pc    = pc;
        tick();
        req_i_valid = 1'b0;
        bus_arready = 1'b1;
        settle();
        chk("fetch_araddr", bus_araddr, pc);
        tick();
        bus_arready = 1'b0;
        bus_rvalid  = 1'b1;
        bus_rdata   = data;
        bus_rresp   = resp;
        tick();
        bus_rvalid  = 1'b0;
        bus_rresp   = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req_i_valid = 1'b0; req_i_pc = '0; req_i_flush = 1'b0;
        bus_arready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_rresp = 2'b00;
        rsp_o_ready = 1'b0;
        tick(); tick();
        settle();
        chk("rst_req_ready", req_i_ready, 1);
        chk("rst_arvalid",   bus_arvalid, 0);
        chk("rst_rready",    bus_rready,  0);
        chk("rst_rsp_valid", rsp_o_valid, 0);
        chk("rst_ifsh",      rsp_o_ifsh,  0);
        rst = 1'b0;
        tick();

        // Basic fetch with arready after 1 cycle and rvalid after 2.
        req_i_valid = 1'b1; req_i_pc = 32'h8000_0000;
        settle();
        chk("basic_req_ready", req_i_ready, 1);
        tick();
        req_i_valid = 1'b0;
        settle();
        chk("basic_arvalid", bus_arvalid, 1);
        chk("basic_araddr",  bus_araddr, 32'h8000_0000);
        tick();
        bus_arready = 1'b1;
        settle();
        chk("basic_arvalid_held", bus_arvalid, 1);
        tick();
        bus_arready = 1'b0;
        settle();
        chk("basic_rready", bus_rready, 1);
        chk("basic_arvalid_off", bus_arvalid, 0);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_0013;
        tick();
        bus_rvalid = 1'b0; rsp_o_ready = 1'b1;
        settle();
        chk("basic_valid", rsp_o_valid, 1);
        chk("basic_pc",    rsp_o_pc, 32'h8000_0000);
        chk("basic_instr", rsp_o_instr, 32'h13);
        chk("basic_err",   rsp_o_err, 0);
        chk("basic_ifsh",  rsp_o_ifsh, 1);
        tick();
        settle();
        chk("basic_idle_valid", rsp_o_valid, 0);
        chk("basic_idle_ifsh",  rsp_o_ifsh, 0);
        rsp_o_ready = 1'b0;

        // Back-pressure: outputs hold, no new request accepted.
        do_fetch(32'h8000_0004, 32'h0010_0093, 2'b00);
        req_i_valid = 1'b1; req_i_pc = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_valid",     rsp_o_valid, 1);
            chk("bp_instr",     rsp_o_instr, 32'h0010_0093);
            chk("bp_pc",        rsp_o_pc, 32'h8000_0004);
            chk("bp_req_ready", req_i_ready, 0);
            chk("bp_arvalid",   bus_arvalid, 0);
            chk("bp_ifsh",      rsp_o_ifsh, 0);
            tick();
        end
        req_i_valid = 1'b0; rsp_o_ready = 1'b1;
        settle();
        chk("bp_release_ifsh", rsp_o_ifsh, 1);
        tick();
        settle();
        chk("bp_after_arvalid", bus_arvalid, 0);
        rsp_o_ready = 1'b0;

        // Flush in R: old beat dropped, flush PC fetched next.
        req_i_valid = 1'b1; req_i_pc = 32'h8000_0010;
        tick();
        req_i_valid = 1'b0; bus_arready = 1'b1;
        tick();
        bus_arready = 1'b0;
        req_i_flush = 1'b1; req_i_valid = 1'b1; req_i_pc = 32'h8000_0100;
        settle();
        chk("flr_req_ready", req_i_ready, 1);
        tick();
        req_i_flush = 1'b0; req_i_valid = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; rsp_o_ready = 1'b1;
        settle();
        chk("flr_rready", bus_rready, 1);
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("flr_no_valid", rsp_o_valid, 0);
        chk("flr_arvalid",  bus_arvalid, 1);
        chk("flr_araddr",   bus_araddr, 32'h8000_0100);
        bus_arready = 1'b1;
        tick();
        bus_arready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0033;
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("flr_pc",    rsp_o_pc, 32'h8000_0100);
        chk("flr_instr", rsp_o_instr, 32'h33);
        chk("flr_ifsh",  rsp_o_ifsh, 1);
        tick();
        rsp_o_ready = 1'b0;

        // Double flush in AR: only the second PC is fetched.
        req_i_valid = 1'b1; req_i_pc = 32'h8000_0020;
        tick();
        req_i_valid = 1'b0;
        req_i_flush = 1'b1; req_i_pc = 32'h8000_0100;
        tick();
        req_i_pc = 32'h8000_0200;
        tick();
        req_i_flush = 1'b0;
        settle();
        chk("dfl_araddr_stable", bus_araddr, 32'h8000_0020);
        chk("dfl_arvalid_held",  bus_arvalid, 1);
        bus_arready = 1'b1;
        tick();
        bus_arready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("dfl_no_valid", rsp_o_valid, 0);
        chk("dfl_araddr",   bus_araddr, 32'h8000_0200);
        bus_arready = 1'b1;
        tick();
        bus_arready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0044;
        tick();
        bus_rvalid = 1'b0; rsp_o_ready = 1'b1;
        settle();
        chk("dfl_pc",    rsp_o_pc, 32'h8000_0200);
        chk("dfl_instr", rsp_o_instr, 32'h44);
        tick();
        rsp_o_ready = 1'b0;

        // Bus error response.
        do_fetch(32'h8000_0040, 32'h0000_0055, 2'b10);
        rsp_o_ready = 1'b1;
        settle();
        chk("err_valid", rsp_o_valid, 1);
        chk("err_flag",  rsp_o_err, 1);
        chk("err_pc",    rsp_o_pc, 32'h8000_0040);
        tick();
        rsp_o_ready = 1'b0;

        // Flush while in OUT: response suppressed, flush PC fetched.
        do_fetch(32'h8000_0050, 32'h0000_0066, 2'b00);
        req_i_flush = 1'b1; req_i_valid = 1'b1; req_i_pc = 32'h8000_0300; rsp_o_ready = 1'b1;
        settle();
        chk("flo_valid", rsp_o_valid, 0);
        chk("flo_ifsh",  rsp_o_ifsh, 0);
        tick();
        req_i_flush = 1'b0; req_i_valid = 1'b0;
        settle();
        chk("flo_araddr", bus_araddr, 32'h8000_0300);
        bus_arready = 1'b1;
        tick();
        bus_arready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0077;
        tick();
        bus_rvalid = 1'b0;
        // Zero-bubble: handshake plus new request in the same cycle.
        req_i_valid = 1'b1; req_i_pc = 32'h8000_0304;
        settle();
        chk("zb_ifsh",      rsp_o_ifsh, 1);
        chk("zb_req_ready", req_i_ready, 1);
        chk("zb_instr",     rsp_o_instr, 32'h77);
        tick();
        req_i_valid = 1'b0;
        settle();
        chk("zb_arvalid", bus_arvalid, 1);
        chk("zb_araddr",  bus_araddr, 32'h8000_0304);

        // Reset mid-transaction returns to idle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("mrst_arvalid",   bus_arvalid, 0);
        chk("mrst_req_ready", req_i_ready, 1);
        tick();

        // Misaligned PC handling.
        rsp_o_ready = 1'b0;
        req_i_valid = 1'b1; req_i_pc = 32'h8000_0002;
        tick();
        req_i_valid = 1'b0;
        settle();
`ifdef LIEAT_IFU_MISALIGN_CHK_EN
        chk("mis_arvalid", bus_arvalid, 0);
        chk("mis_valid",   rsp_o_valid, 1);
        chk("mis_err",     rsp_o_err, 1);
        chk("mis_instr",   rsp_o_instr, 0);
        chk("mis_pc",      rsp_o_pc, 32'h8000_0002);
`else
        chk("mis_arvalid", bus_arvalid, 1);
        chk("mis_araddr",  bus_araddr, 32'h8000_0002);
        bus_arready = 1'b1;
        tick();
        bus_arready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0088;
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("mis_err",   rsp_o_err, 0);
        chk("mis_instr", rsp_o_instr, 32'h88);
`endif
        rsp_o_ready = 1'b1;
        tick();
        rsp_o_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
